m_divider: RTL and testbench

Sequential unsigned integer divider: given a dividend and divisor, it produces a quotient and remainder using the restoring shift-subtract algorithm, one quotient bit per clock. It is the inverse arithmetic path to the datapath's combinational ripple-carry adder and sits beside it in the ALU as the multi-cycle DIV/REM unit. A start/busy/valid handshake connects it to the issuing controller.

---
 rtl/m_divider.sv | 128 ++++++++++++
 tb/tb_m_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/m_divider.sv
// ============================================================================
//  m_divider : sequential restoring shift-subtract unsigned divider,
//              one quotient bit per clock, start/busy/valid handshake.
//  Revision  : 1.0
// ============================================================================
`default_nettype none

module m_divider #(
    parameter int WIDTH = 32
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_start,
    input  logic [WIDTH-1:0] w_dividend,
    input  logic [WIDTH-1:0] w_divisor,
    output logic             w_busy,
    output logic             w_valid,
    output logic [WIDTH-1:0] w_quotient,
    output logic [WIDTH-1:0] w_remainder,
    output logic             w_div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             valid_q, valid_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   w_partial;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // Partial < 2*divisor, so a successful subtraction always fits in WIDTH bits.
    assign w_partial  = {rem_q, dvd_q[WIDTH-1]};
    assign w_ge       = (w_partial >= {1'b0, dvs_q});
    assign w_diff     = w_partial[WIDTH-1:0] - dvs_q;
    assign w_rem_next = w_ge ? w_diff : w_partial[WIDTH-1:0];
    assign w_quo_next = {quo_q[WIDTH-2:0], w_ge};

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        valid_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    dvd_d   = w_dividend;
                    dvs_d   = w_divisor;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                rem_d = w_rem_next;
                quo_d = w_quo_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quotient_d  = w_quo_next;
                    remainder_d = w_rem_next;
                    dbz_d       = (dvs_q == '0);
                    valid_d     = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            valid_q     <= valid_d;
            dbz_q       <= dbz_d;
        end
    end

    assign w_busy        = (state_q == S_BUSY);
    assign w_valid       = valid_q;
    assign w_quotient    = quotient_q;
    assign w_remainder   = remainder_q;
    assign w_div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_m_divider.sv
// ============================================================================
//  tb_m_divider : table-driven and directed self-checking bench for m_divider.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_m_divider;

    localparam int WIDTH = 32;
    localparam int LAT   = 32;

    logic             w_clk;
    logic             w_rst;
    logic             w_start;
    logic [WIDTH-1:0] w_dividend;
    logic [WIDTH-1:0] w_divisor;
    logic             w_busy;
    logic             w_valid;
    logic [WIDTH-1:0] w_quotient;
    logic [WIDTH-1:0] w_remainder;
    logic             w_div_by_zero;

    int total = 0;
    int bad   = 0;

    m_divider #(.WIDTH(WIDTH)) dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .w_start      (w_start),
        .w_dividend   (w_dividend),
        .w_divisor    (w_divisor),
        .w_busy       (w_busy),
        .w_valid      (w_valid),
        .w_quotient   (w_quotient),
        .w_remainder  (w_remainder),
        .w_div_by_zero(w_div_by_zero)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [WIDTH-1:0] dividend;
        logic [WIDTH-1:0] divisor;
        logic [WIDTH-1:0] exp_q;
        logic [WIDTH-1:0] exp_r;
        logic             exp_dbz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive a one-cycle start at a negedge; returns at the negedge after the accepting edge.
    task automatic kick(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        w_dividend = a;
        w_divisor  = b;
        w_start    = 1'b1;
        @(negedge w_clk);
        w_start    = 1'b0;
    endtask

    // Called at a negedge that is start_cyc cycles after the accepting edge.
    task automatic wait_result(input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                               input logic edbz, input string name, input int start_cyc);
        int cyc     = start_cyc;
        bit busy_ok = 1'b1;
        while (!w_valid && cyc < LAT + 40) begin
            if (!w_busy) busy_ok = 1'b0;
            @(negedge w_clk);
            cyc++;
        end
        check({name, "_latency"}, WIDTH'(cyc), WIDTH'(LAT));
        check({name, "_busy_held"}, WIDTH'(busy_ok), WIDTH'(1));
        check({name, "_busy_low_at_valid"}, WIDTH'(w_busy), WIDTH'(0));
        check({name, "_quotient"}, w_quotient, eq);
        check({name, "_remainder"}, w_remainder, er);
        check({name, "_dbz"}, WIDTH'(w_div_by_zero), WIDTH'(edbz));
    endtask

    initial begin
        logic [WIDTH-1:0] a, b, q, r;
        bit               rnd_ok;
        bit               quiet;

        vecs[0] = '{32'd4444,       32'd321,        32'd13,         32'd271, 1'b0};
        vecs[1] = '{32'd2048,       32'd1024,       32'd2,          32'd0,   1'b0};
        vecs[2] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0};
        vecs[3] = '{32'd5,          32'd9,          32'd0,          32'd5,   1'b0};
        vecs[4] = '{32'd0,          32'd7,          32'd0,          32'd0,   1'b0};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,   1'b0};
        vecs[6] = '{32'd7,          32'd0,          32'hFFFF_FFFF,  32'd7,   1'b1};
        vecs[7] = '{32'd9,          32'd3,          32'd3,          32'd0,   1'b0};

        w_rst      = 1'b1;
        w_start    = 1'b0;
        w_dividend = '0;
        w_divisor  = '0;
        repeat (3) @(negedge w_clk);
        w_rst = 1'b0;
        @(negedge w_clk);

        check("reset_busy", WIDTH'(w_busy), WIDTH'(0));
        check("reset_valid", WIDTH'(w_valid), WIDTH'(0));
        check("reset_quotient", w_quotient, '0);
        check("reset_remainder", w_remainder, '0);
        check("reset_dbz", WIDTH'(w_div_by_zero), WIDTH'(0));

        for (int i = 0; i < 8; i++) begin
            kick(vecs[i].dividend, vecs[i].divisor);
            wait_result(vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dbz, $sformatf("vec%0d", i), 0);
            @(negedge w_clk);
            check($sformatf("vec%0d_valid_pulse", i), WIDTH'(w_valid), WIDTH'(0));
        end

        // Start asserted mid-operation must be ignored and not queued.
        kick(32'd100, 32'd7);
        repeat (9) @(negedge w_clk);
        kick(32'd50, 32'd5);
        wait_result(32'd14, 32'd2, 1'b0, "ignore_start", 10);
        quiet = 1'b1;
        repeat (40) begin
            @(negedge w_clk);
            if (w_valid || w_busy) quiet = 1'b0;
        end
        check("no_queue", WIDTH'(quiet), WIDTH'(1));
        check("hold_quotient", w_quotient, 32'd14);

        // New start accepted in the w_valid cycle.
        kick(32'd100, 32'd7);
        wait_result(32'd14, 32'd2, 1'b0, "b2b_first", 0);
        kick(32'd50, 32'd5);
        wait_result(32'd10, 32'd0, 1'b0, "b2b_second", 0);
        @(negedge w_clk);

        // Asynchronous reset mid-operation.
        kick(32'd1000, 32'd3);
        repeat (15) @(negedge w_clk);
        #2 w_rst = 1'b1;
        #1;
        check("midrst_busy", WIDTH'(w_busy), WIDTH'(0));
        check("midrst_quotient", w_quotient, '0);
        check("midrst_remainder", w_remainder, '0);
        check("midrst_dbz", WIDTH'(w_div_by_zero), WIDTH'(0));
        quiet = 1'b1;
        repeat (3) begin
            @(negedge w_clk);
            if (w_valid) quiet = 1'b0;
        end
        w_rst = 1'b0;
        repeat (40) begin
            @(negedge w_clk);
            if (w_valid || w_busy) quiet = 1'b0;
        end
        check("midrst_no_valid", WIDTH'(quiet), WIDTH'(1));
        kick(32'd1000, 32'd3);
        wait_result(32'd333, 32'd1, 1'b0, "after_rst", 0);
        @(negedge w_clk);

        // Random operands against a reference model and the division invariant.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case (i % 3)
                0:       b = WIDTH'($urandom_range(1, 255));
                1:       b = WIDTH'($urandom_range(1, 65535));
                default: b = $urandom;
            endcase
            if (b == '0) b = 32'd1;
            q = a / b;
            r = a % b;
            kick(a, b);
            wait_result(q, r, 1'b0, $sformatf("rnd%0d", i), 0);
            rnd_ok = ({32'd0, w_quotient} * {32'd0, b} + {32'd0, w_remainder} == {32'd0, a})
                     && (w_remainder < b);
            check($sformatf("rnd%0d_invariant", i), WIDTH'(rnd_ok), WIDTH'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
